uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter used by the Segway serial link. Data width and stop-bit count are set at build time. The baud divisor is a run-time input, so one block serves the telemetry and debug links. Sits between the command/telemetry logic (trmt/tx_data handshake) and the TX pin.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
DIV_W, 12, width of the baud_div input and of the internal baud counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trmt  input  1  transmit request; single-cycle or level, sampled every clk
tx_data  input  DATA_BITS  payload; captured on an accepted trmt
baud_div  input  DIV_W  clocks per bit; captured on an accepted trmt
TX  output  1  serial line; idle high
tx_done  output  1  sticky frame-complete flag
busy  output  1  high while a frame is in progress

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. All flops reset asynchronously.
- Reset values: TX=1, tx_done=0, busy=0, state=IDLE, counters=0.
- States are IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: trmt=1 at edge k accepts a request.
  - At edge k: capture tx_data and baud_div, clear tx_done, set busy, go to START.
  - TX falls to 0 at edge k (registered output), visible in cycle k+1.
- Bit timing:
  - Every bit lasts exactly div_eff clock cycles.
  - div_eff = captured baud_div, except that values 0, 1 and 2 are forced to 2.
  - The baud counter resets at each bit boundary.
- START: 1 bit of 0.
- DATA: DATA_BITS bits, LSB first. The bit counter counts 0..DATA_BITS-1.
- STOP: STOP_BITS bits of 1.
- End of frame, at the edge where the last stop bit completes:
  - go to IDLE, set tx_done=1, clear busy, hold TX=1.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * div_eff clocks, where P=1 if a parity bit is sent, else 0.
- Back-to-back frames: the earliest next accept is the edge after the frame ends. With trmt held high, frames are separated by exactly 1 idle-high clock.
- trmt while busy is ignored: no queueing, no corruption of the frame in flight.
- Changes to tx_data or baud_div while busy have no effect on the current frame.
- tx_done stays high until the next accepted trmt or reset.
- Reset mid-frame: TX returns to 1 immediately (asynchronously), tx_done=0, busy=0. No partial frame resumes.
- The baud counter is DIV_W bits and never wraps within a bit, because it is cleared at div_eff-1.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds input par_en (1 bit) and input par_odd (1 bit); both are captured on an accepted trmt.
  - When par_en=1, a PARITY state follows DATA and sends one bit before the stop bits.
  - Parity bit = XOR of the payload bits; it is inverted when par_odd=1.
  - When par_en=0, the frame is identical to the macro-undefined behaviour.
- Undefined:
  - par_en and par_odd ports do not exist.
  - There is no PARITY state, and P=0 always.

Test Plan:
1. DATA_BITS=8, STOP_BITS=1, baud_div=16, tx_data=0xA5, 1-cycle trmt -> TX sequence 0,1,0,1,0,0,1,0,1,1, each level held 16 clocks. tx_done rises exactly 160 clocks after the accepting edge.
2. trmt pulses at clocks 20 and 100 of the frame, with tx_data changed to 0x3C and baud_div changed to 8 mid-frame -> the frame is unchanged (0xA5 at 16 clocks/bit). No second frame starts. busy stays high for exactly 160 clocks.
3. trmt held high, tx_data=0x55, baud_div=4 -> consecutive frames of 40 clocks, separated by exactly 1 high clock. tx_done pulses low 1 clock after each new accept.
4. rst_n asserted at clock 70 of a frame -> TX=1, busy=0, tx_done=0 immediately. After release, a trmt with 0x0F sends a clean frame.
5. baud_div=0 and baud_div=1 -> each bit lasts 2 clocks. STOP_BITS=2 with baud_div=10 -> frame length 110 clocks, with a 20-clock high stop period.
6. With UART_TX_PARITY_EN, tx_data=0xA5, par_en=1:
   - par_odd=0 -> parity bit 0, frame length 11*div_eff.
   - par_odd=1 -> parity bit 1.
   - par_en=0 -> 10-bit frame.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: DATA_BITS payload, STOP_BITS stop bits, run-time baud divisor.
// Optional parity bit (par_en/par_odd ports) is built in when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [DIV_W-1:0]     baud_div,
`ifdef UART_TX_PARITY_EN
    input  logic                 par_en,
    input  logic                 par_odd,
`endif
    output logic                 TX,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`endif

    // div_q always holds the effective divisor (>= 2), so div_q-1 never underflows.
    assign bit_end = (baud_cnt_q == div_q - DIV_W'(1));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = done_q;
        busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                if (trmt) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    div_d      = (baud_div < DIV_W'(3)) ? DIV_W'(2) : baud_div;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = par_en;
                    par_bit_d  = (^tx_data) ^ par_odd;
`endif
                end
            end
            default: begin
                if (!bit_end) begin
                    baud_cnt_d = baud_cnt_q + DIV_W'(1);
                end else begin
                    baud_cnt_d = '0;
                    case (state_q)
                        START: begin
                            state_d   = DATA;
                            tx_d      = shift_q[0];
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = '0;
                        end
                        DATA: begin
                            if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                                bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                                if (par_en_q) begin
                                    state_d = PARITY;
                                    tx_d    = par_bit_q;
                                end else
`endif
                                begin
                                    state_d = STOP;
                                    tx_d    = 1'b1;
                                end
                            end else begin
                                tx_d      = shift_q[0];
                                shift_d   = shift_q >> 1;
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state_d   = STOP;
                            tx_d      = 1'b1;
                            bit_cnt_d = '0;
                        end
`endif
                        STOP: begin
                            if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                tx_d    = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // NOTE: the datapath registers reset too, so an aborted frame leaves no stale payload behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            div_q      <= DIV_W'(2);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign TX      = tx_q;
    assign tx_done = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames are queued at send time and
// checked bit-by-bit by a line monitor. Two instances: STOP_BITS=1 and STOP_BITS=2.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt, trmt2;
    logic [7:0] tx_data;
    logic [11:0] baud_div;
    logic       par_en, par_odd;
    logic       tx1, done1, busy1, tx2, done2, busy2;
    logic       sel;
    logic       mon_en;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(1), .DIV_W(12)) dut1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .baud_div(baud_div),
`ifdef UART_TX_PARITY_EN
        .par_en(par_en), .par_odd(par_odd),
`endif
        .TX(tx1), .tx_done(done1), .busy(busy1)
    );

    uart_tx_cfg #(.DATA_BITS(8), .STOP_BITS(2), .DIV_W(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt2), .tx_data(tx_data), .baud_div(baud_div),
`ifdef UART_TX_PARITY_EN
        .par_en(par_en), .par_odd(par_odd),
`endif
        .TX(tx2), .tx_done(done2), .busy(busy2)
    );

    wire mon_tx   = sel ? tx2   : tx1;
    wire mon_done = sel ? done2 : done1;
    wire mon_busy = sel ? busy2 : busy1;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         nstop;
        int         par;    // -1: no parity bit, else the expected bit
        bit         b2b;    // next frame expected right after a 1-clock gap
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   frames_pushed = 0;
    int   frames_done = 0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int div_eff(input int d);
        return (d < 3) ? 2 : d;
    endfunction

    function automatic exp_t mk(input logic [7:0] d, input int div, input int ns, input bit b2b);
        exp_t e;
        e.data  = d;
        e.div   = div_eff(div);
        e.nstop = ns;
        e.par   = (par_en === 1'b1) ? int'((^d) ^ par_odd) : -1;
        e.b2b   = b2b;
        return e;
    endfunction

    // Entered on the first negedge of the start bit; returns on the negedge after tx_done rises.
    task automatic check_frame(input exp_t e);
        int nb, busy_err, done_err, bit_err;
        logic expb;
        nb = 1 + 8 + ((e.par >= 0) ? 1 : 0) + e.nstop;
        busy_err = 0;
        done_err = 0;
        check("done_clr", int'(mon_done), 0);
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                       expb = 1'b0;
            else if (b <= 8)                  expb = e.data[b-1];
            else if (e.par >= 0 && b == 9)    expb = e.par[0];
            else                              expb = 1'b1;
            bit_err = 0;
            for (int c = 0; c < e.div; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (mon_tx !== expb)    bit_err++;
                if (mon_busy !== 1'b1)  busy_err++;
                if (mon_done !== 1'b0)  done_err++;
            end
            check($sformatf("bit%0d_errs", b), bit_err, 0);
        end
        check("busy_in_frame_errs", busy_err, 0);
        check("done_early_errs", done_err, 0);
        @(negedge clk);
        check("done_set", int'(mon_done), 1);
        check("busy_clr", int'(mon_busy), 0);
        check("tx_idle", int'(mon_tx), 1);
        frames_done++;
    endtask

    initial begin : monitor
        exp_t e;
        bit more;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n === 1'b1 && mon_tx === 1'b0) begin
                more = 1'b1;
                while (more) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        more = 1'b0;
                    end else begin
                        e = sb.pop_front();
                        check_frame(e);
                        more = e.b2b;
                        if (more) begin
                            @(negedge clk);
                            check("b2b_gap_start", int'(mon_tx), 0);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input exp_t e);
        sb.push_back(e);
        frames_pushed++;
    endtask

    task automatic send(input logic [7:0] d, input int div, input int ns);
        @(negedge clk);
        tx_data  = d;
        baud_div = 12'(div);
        push(mk(d, div, ns, 1'b0));
        if (sel) trmt2 = 1'b1; else trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt  = 1'b0;
        trmt2 = 1'b0;
    endtask

    task automatic wait_frames(input int budget);
        int n = 0;
        while (frames_done < frames_pushed && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", frames_done, frames_pushed);
    endtask

    initial begin : stim
        int err;
        rst_n = 1'b0; trmt = 1'b0; trmt2 = 1'b0; tx_data = 8'h00; baud_div = 12'd16;
        par_en = 1'b0; par_odd = 1'b0; sel = 1'b0; mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx1), 1);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_tx2", int'(tx2), 1);
        rst_n = 1'b1;

        // Basic 0xA5 frame at 16 clocks/bit.
        send(8'hA5, 16, 1);
        wait_frames(400);

        // Requests and input changes while busy must not disturb the frame.
        send(8'hA5, 16, 1);
        repeat (19) @(negedge clk);
        tx_data = 8'h3C; baud_div = 12'd8; trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (79) @(negedge clk);
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        wait_frames(400);
        err = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy1 !== 1'b0 || tx1 !== 1'b1) err++;
        end
        check("no_second_frame", err, 0);

        // trmt held high: three back-to-back 40-clock frames.
        @(negedge clk);
        tx_data = 8'h55; baud_div = 12'd4;
        push(mk(8'h55, 4, 1, 1'b1));
        push(mk(8'h55, 4, 1, 1'b1));
        push(mk(8'h55, 4, 1, 1'b0));
        trmt = 1'b1;
        repeat (83) @(posedge clk);
        #1 trmt = 1'b0;
        wait_frames(400);

        // Reset mid-frame, then a clean frame.
        mon_en = 1'b0;
        @(negedge clk);
        tx_data = 8'hA5; baud_div = 12'd16; trmt = 1'b1;
        @(posedge clk);
        #1 trmt = 1'b0;
        repeat (69) @(posedge clk);
        #2;
        check("pre_rst_busy", int'(busy1), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", int'(tx1), 1);
        check("midrst_busy", int'(busy1), 0);
        check("midrst_done", int'(done1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", int'(tx1), 1);
        mon_en = 1'b1;
        send(8'h0F, 16, 1);
        wait_frames(400);

        // Divisor clamping and the two-stop-bit instance.
        send(8'h96, 0, 1);
        wait_frames(100);
        send(8'h69, 1, 1);
        wait_frames(100);
        sel = 1'b1;
        send(8'hC3, 10, 2);
        wait_frames(300);
        sel = 1'b0;

`ifdef UART_TX_PARITY_EN
        par_en = 1'b1; par_odd = 1'b0;
        send(8'hA5, 4, 1);
        wait_frames(200);
        par_odd = 1'b1;
        send(8'hA5, 4, 1);
        wait_frames(200);
        par_en = 1'b0;
        send(8'hA5, 4, 1);
        wait_frames(200);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
